// File: rtl/cpack_ts_pkg.sv
// Shared types and sizing helpers for util_cpack_ts_stream.
// Contents:
//   cpack_state_e - packer state (IDLE latches K, RUN packs, ERR waits for resync)
//   LEVEL_W/CNT_W - widths for the default 4-channel build
//   level_w/cnt_w - the same widths for any channel count
package cpack_ts_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } cpack_state_e;

  localparam int NUM_OF_CHANNELS_DFLT = 4;
  localparam int LEVEL_W = $clog2(2 * NUM_OF_CHANNELS_DFLT);
  localparam int CNT_W   = $clog2(NUM_OF_CHANNELS_DFLT + 1);

  // A 1-channel build still needs a 1-bit level.
  function automatic int level_w(input int n);
    return (n < 2) ? 1 : $clog2(2 * n);
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/util_cpack_ts_stream_if.sv
// Output beat stream of the timestamp packer.
// Signals:
//   data_out_valid/data_out_ready - beat handshake
//   data_out      - NUM_OF_CHANNELS words, word 0 in LSBs
//   data_out_sync - word 0 is a channel-0 sample
//   timestamp_out - timestamp of the input cycle that supplied word 0
// Modports: master = packer (beat source), slave = downstream sink.
interface util_cpack_ts_stream_if #(
  parameter int NUM_OF_CHANNELS = 4,
  parameter int CHANNEL_WIDTH   = 16,
  parameter int TIMESTAMP_WIDTH = 64
);
  logic                                       data_out_valid;
  logic                                       data_out_ready;
  logic                                       data_out_sync;
  logic [NUM_OF_CHANNELS*CHANNEL_WIDTH-1:0]   data_out;
  logic [TIMESTAMP_WIDTH-1:0]                 timestamp_out;

  modport master (
    output data_out_valid, data_out_sync, data_out, timestamp_out,
    input  data_out_ready
  );

  modport slave (
    input  data_out_valid, data_out_sync, data_out, timestamp_out,
    output data_out_ready
  );
endinterface

// File: rtl/cpack_ts_out_reg.sv
// One-beat valid/ready holding register with drop-on-full.
// Ports:
//   clk, resetn          - clock, async active-low reset
//   in_valid/in_*        - completed beat offered this cycle (no backpressure)
//   out_ready/out_*      - registered beat towards downstream
//   overflow             - sticky: a beat arrived while full and not drained
// A beat arriving while the register is full and not being accepted is
// dropped; the held beat stays untouched so downstream sees stable data.
module cpack_ts_out_reg #(
  parameter int DATA_W = 64,
  parameter int TS_W   = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  input  logic              in_sync,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TS_W-1:0]   in_ts,
  input  logic              out_ready,
  output logic              out_valid,
  output logic              out_sync,
  output logic [DATA_W-1:0] out_data,
  output logic [TS_W-1:0]   out_ts,
  output logic              overflow
);

  logic load;
  assign load = in_valid && (!out_valid || out_ready);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_sync  <= 1'b0;
      out_data  <= '0;
      out_ts    <= '0;
      overflow  <= 1'b0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_sync  <= in_sync;
        out_data  <= in_data;
        out_ts    <= in_ts;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (in_valid && out_valid && !out_ready)
        overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/util_cpack_ts_stream.sv
// Timestamped channel packer: packs K enabled channels per input cycle into
// NUM_OF_CHANNELS-word beats; each beat carries the timestamp of the input
// cycle that supplied its word 0.
// Ports:
//   clk, resetn          - clock, async active-low reset
//   enabled_chan_count   - K, latched in IDLE only
//   resync               - drop partial beat, go back to IDLE to re-latch K
//   en/data_in/timestamp_in - input sample cycle
//   flush                - (CPACK_TS_FLUSH_EN only) emit partial beat zero-filled
//   overflow             - sticky dropped-beat flag
//   config_err           - latched K was 0 or above NUM_OF_CHANNELS
//   beat                 - output beat stream (master modport)
// Build option: define CPACK_TS_FLUSH_EN to add the flush port.
module util_cpack_ts_stream
  import cpack_ts_pkg::*;
#(
  parameter int NUM_OF_CHANNELS = 4,
  parameter int CHANNEL_WIDTH   = 16,
  parameter int TIMESTAMP_WIDTH = 64
) (
  input  logic                                     clk,
  input  logic                                     resetn,
  input  logic [$clog2(NUM_OF_CHANNELS+1)-1:0]     enabled_chan_count,
  input  logic                                     resync,
  input  logic                                     en,
  input  logic [NUM_OF_CHANNELS*CHANNEL_WIDTH-1:0] data_in,
  input  logic [TIMESTAMP_WIDTH-1:0]               timestamp_in,
`ifdef CPACK_TS_FLUSH_EN
  input  logic                                     flush,
`endif
  output logic                                     overflow,
  output logic                                     config_err,
  util_cpack_ts_stream_if.master                   beat
);

  localparam int N  = NUM_OF_CHANNELS;
  localparam int W  = CHANNEL_WIDTH;
  localparam int AW = 2 * N * W;
  // Package constants cover the default build; other sizes use the helpers.
  localparam int LW = (N == NUM_OF_CHANNELS_DFLT) ? LEVEL_W : level_w(N);
  localparam int CW = (N == NUM_OF_CHANNELS_DFLT) ? CNT_W   : cnt_w(N);

  cpack_state_e               state;
  logic [CW-1:0]              k_q;
  logic [LW-1:0]              level;
  logic [AW-1:0]              acc;       // 2N words, word 0 in LSBs
  logic [TIMESTAMP_WIDTH-1:0] pend_ts;
  logic                       pend_sync;

  logic                       take;
  logic [AW-1:0]              kmask, acc_wr, acc_a;
  int                         sh;
  logic [LW:0]                total;
  logic [LW-1:0]              rem, lvl_a, level_nxt;
  logic [TIMESTAMP_WIDTH-1:0] ts_now, ts_a;
  logic                       sync_now, sync_a;
  logic                       beat_done;

  logic                       beat_vld, beat_sync;
  logic [N*W-1:0]             beat_data;
  logic [TIMESTAMP_WIDTH-1:0] beat_ts;

  // resync beats a simultaneous en.
  assign take = (state == RUN) && en && !resync;

  // Append K words at the current level, then split off a full beat if the
  // accumulator reached N words. Leftover words are the tail of this cycle's
  // samples, so their beat starts mid-frame (sync=0) with this timestamp.
  always_comb begin
    kmask = '0;
    for (int j = 0; j < N; j++)
      if (CW'(j) < k_q) kmask[j*W +: W] = {W{1'b1}};
    sh       = int'(level) * W;
    acc_wr   = acc;
    total    = {1'b0, level};
    ts_now   = pend_ts;
    sync_now = pend_sync;
    if (take) begin
      acc_wr = (acc & ~(kmask << sh)) | (({{(N*W){1'b0}}, data_in} & kmask) << sh);
      total  = {1'b0, level} + (LW+1)'(k_q);
      if (level == '0) begin
        ts_now   = timestamp_in;
        sync_now = 1'b1;
      end
    end
    beat_done = take && (total >= (LW+1)'(N));
    rem       = LW'(total - (LW+1)'(N));
    if (beat_done) begin
      acc_a  = acc_wr >> (N * W);
      lvl_a  = rem;
      ts_a   = timestamp_in;
      sync_a = 1'b0;
    end else begin
      acc_a  = acc_wr;
      lvl_a  = total[LW-1:0];
      ts_a   = ts_now;
      sync_a = sync_now;
    end
  end

`ifdef CPACK_TS_FLUSH_EN
  // Only one beat can leave per cycle: if en completes a beat and leaves a
  // remainder in the same cycle as a flush, the flush is held over and
  // applied on the next cycle that does not complete a beat.
  logic           flush_q, flush_req, flush_go;
  logic [N*W-1:0] lowmask;

  assign flush_req = (state == RUN) && !resync && (flush || flush_q);
  assign flush_go  = flush_req && !beat_done && (lvl_a != '0);
  assign lowmask   = ~({(N*W){1'b1}} << (int'(lvl_a) * W));
  assign beat_vld  = beat_done || flush_go;
  assign beat_data = flush_go ? (acc_a[N*W-1:0] & lowmask) : acc_wr[N*W-1:0];
  assign beat_ts   = flush_go ? ts_a   : ts_now;
  assign beat_sync = flush_go ? sync_a : sync_now;
  assign level_nxt = flush_go ? '0     : lvl_a;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) flush_q <= 1'b0;
    else         flush_q <= flush_req && beat_done && (lvl_a != '0);
  end
`else
  assign beat_vld  = beat_done;
  assign beat_data = acc_wr[N*W-1:0];
  assign beat_ts   = ts_now;
  assign beat_sync = sync_now;
  assign level_nxt = lvl_a;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      k_q        <= '0;
      level      <= '0;
      acc        <= '0;
      pend_ts    <= '0;
      pend_sync  <= 1'b0;
      config_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          k_q <= enabled_chan_count;
          if (enabled_chan_count != '0 && enabled_chan_count <= CW'(N)) begin
            state      <= RUN;
            config_err <= 1'b0;
          end else begin
            state      <= ERR;
            config_err <= 1'b1;
          end
        end
        RUN: begin
          if (resync) begin
            level <= '0;
            state <= IDLE;
          end else begin
            level     <= level_nxt;
            acc       <= acc_a;
            pend_ts   <= ts_a;
            pend_sync <= sync_a;
          end
        end
        ERR:     if (resync) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  cpack_ts_out_reg #(
    .DATA_W (N * W),
    .TS_W   (TIMESTAMP_WIDTH)
  ) u_out (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (beat_vld),
    .in_sync   (beat_sync),
    .in_data   (beat_data),
    .in_ts     (beat_ts),
    .out_ready (beat.data_out_ready),
    .out_valid (beat.data_out_valid),
    .out_sync  (beat.data_out_sync),
    .out_data  (beat.data_out),
    .out_ts    (beat.timestamp_out),
    .overflow  (overflow)
  );

endmodule

// File: tb/tb_util_cpack_ts_stream.sv
// Bench for util_cpack_ts_stream (N=4, W=16, TW=64). A word-queue reference
// model runs alongside every cycle; directed sequences add hand-computed
// expectations, a config table covers K values, and a random phase follows.
module tb_util_cpack_ts_stream;
  localparam int N = 4, W = 16, TW = 64;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [2:0]      cnt = 3'd0;
  logic            resync = 1'b0, en = 1'b0, flush = 1'b0;
  logic [N*W-1:0]  din = '0;
  logic [TW-1:0]   tsin = '0;
  logic            overflow, config_err;

  util_cpack_ts_stream_if #(.NUM_OF_CHANNELS(N), .CHANNEL_WIDTH(W), .TIMESTAMP_WIDTH(TW)) ob ();

  util_cpack_ts_stream #(.NUM_OF_CHANNELS(N), .CHANNEL_WIDTH(W), .TIMESTAMP_WIDTH(TW)) dut (
    .clk                (clk),
    .resetn             (resetn),
    .enabled_chan_count (cnt),
    .resync             (resync),
    .en                 (en),
    .data_in            (din),
    .timestamp_in       (tsin),
`ifdef CPACK_TS_FLUSH_EN
    .flush              (flush),
`endif
    .overflow           (overflow),
    .config_err         (config_err),
    .beat               (ob)
  );

  always #5 clk = ~clk;

  // ---------------- reference model: a queue of words ----------------
  int             m_state;       // 0 idle, 1 run, 2 err
  int             m_k;
  bit             m_err, m_v, m_sy, m_ovf;
  logic [N*W-1:0] m_d;
  logic [TW-1:0]  m_ts;
  logic [W-1:0]   wq[$];
  logic [TW-1:0]  tq[$];
  bit             sq[$];
  int             n_chk = 0, n_fail = 0, sidx = 0;

  function automatic void model_clear();
    wq.delete(); tq.delete(); sq.delete();
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  function automatic void model_step();
    bit bv = 0, bs = 0;
    logic [N*W-1:0] bd = '0;
    logic [TW-1:0]  bt = '0;
    case (m_state)
      0: begin
        m_k = int'(cnt);
        if (m_k >= 1 && m_k <= N) begin m_state = 1; m_err = 0; end
        else begin m_state = 2; m_err = 1; end
      end
      1: begin
        if (resync) begin model_clear(); m_state = 0; end
        else begin
          if (en)
            for (int c = 0; c < m_k; c++) begin
              wq.push_back(din[c*W +: W]); tq.push_back(tsin); sq.push_back(c == 0);
            end
          if (wq.size() >= N) begin
            bv = 1; bt = tq[0]; bs = sq[0];
            for (int j = 0; j < N; j++) begin
              bd[j*W +: W] = wq.pop_front(); void'(tq.pop_front()); void'(sq.pop_front());
            end
          end else if (flush && wq.size() > 0) begin
            bv = 1; bt = tq[0]; bs = sq[0];
            for (int j = 0; wq.size() > 0; j++) bd[j*W +: W] = wq.pop_front();
            model_clear();
          end
        end
      end
      default: if (resync) m_state = 0;
    endcase
    if (bv) begin
      if (!m_v || ob.data_out_ready) begin m_v = 1; m_d = bd; m_ts = bt; m_sy = bs; end
      else m_ovf = 1;
    end else if (ob.data_out_ready) m_v = 0;
  endfunction

  task automatic chk(input string nm, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: model advances, DUT clocks, outputs compared 1 time unit later.
  task automatic cyc();
    model_step();
    @(posedge clk); #1;
    chk("valid", ob.data_out_valid, m_v);
    if (m_v) begin
      chk("data", ob.data_out, m_d);
      chk("ts", ob.timestamp_out, m_ts);
      chk("sync", ob.data_out_sync, m_sy);
    end
    chk("overflow", overflow, m_ovf);
    chk("config_err", config_err, m_err);
  endtask

  // Test-plan sample pattern: channel c of input cycle i = 0x1000+16i+c, ts = 100+i.
  task automatic drive(input bit e);
    en = e;
    for (int c = 0; c < N; c++) din[c*W +: W] = W'(16'h1000 + 16 * sidx + c);
    tsin = TW'(100 + sidx);
    cyc();
    if (e) sidx++;
  endtask

  // Async reset (checked with no clock edge), then the IDLE latch edge.
  task automatic do_reset(input logic [2:0] k);
    resetn = 1'b0; cnt = k; en = 0; resync = 0; flush = 0; ob.data_out_ready = 1'b1;
    #1;
    chk("rst_valid", ob.data_out_valid, 0);
    chk("rst_sync", ob.data_out_sync, 0);
    chk("rst_data", ob.data_out, 0);
    chk("rst_ts", ob.timestamp_out, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_config_err", config_err, 0);
    model_clear();
    m_state = 0; m_k = 0; m_err = 0; m_v = 0; m_sy = 0; m_ovf = 0; m_d = '0; m_ts = '0;
    @(negedge clk); resetn = 1'b1; sidx = 0;
    drive(0);
  endtask

  typedef struct {
    logic [2:0] k;
    bit         err;
    int         beats;   // beats from 20 en cycles with ready=1
  } cfg_vec_t;

  initial begin
    cfg_vec_t tbl[7];
    logic [N*W-1:0] e;
    int nb, first;

    ob.data_out_ready = 1'b1;

    // K=4: a beat per en cycle, latency one edge.
    do_reset(3'd4);
    for (int i = 0; i < 5; i++) begin
      drive(1);
      for (int c = 0; c < N; c++) e[c*W +: W] = W'(16'h1000 + 16 * i + c);
      chk("k4_data", ob.data_out, e);
      chk("k4_ts", ob.timestamp_out, TW'(100 + i));
      chk("k4_sync", ob.data_out_sync, 1);
    end

    // K=3: beats straddle input cycles.
    do_reset(3'd3);
    drive(1);
    chk("k3_nobeat", ob.data_out_valid, 0);
    drive(1);
    chk("k3_b1", ob.data_out, 64'h1010_1002_1001_1000);
    chk("k3_b1ts", ob.timestamp_out, 100);
    chk("k3_b1sync", ob.data_out_sync, 1);
    drive(1);
    chk("k3_b2", ob.data_out, 64'h1021_1020_1012_1011);
    chk("k3_b2ts", ob.timestamp_out, 101);
    chk("k3_b2sync", ob.data_out_sync, 0);
    drive(1);
    chk("k3_b3", ob.data_out, 64'h1032_1031_1030_1022);
    chk("k3_b3ts", ob.timestamp_out, 102);
    chk("k3_b3sync", ob.data_out_sync, 0);

    // K=1 with en toggling: a beat every 8 clocks.
    do_reset(3'd1);
    nb = 0; first = -1;
    for (int i = 0; i < 16; i++) begin
      drive(i % 2 == 0);
      if (ob.data_out_valid) begin
        nb++;
        if (first < 0) begin
          first = i;
          chk("k1_data", ob.data_out, 64'h1030_1020_1010_1000);
          chk("k1_ts", ob.timestamp_out, 100);
          chk("k1_sync", ob.data_out_sync, 1);
        end
      end
    end
    chk("k1_first_cycle", TW'(first), 6);
    chk("k1_beats", TW'(nb), 2);

    // Backpressure: first beat held, next two dropped, overflow sticks.
    do_reset(3'd4);
    ob.data_out_ready = 1'b0;
    drive(1); drive(1); drive(1);
    chk("hold_data", ob.data_out, 64'h1003_1002_1001_1000);
    chk("hold_ts", ob.timestamp_out, 100);
    chk("hold_ovf", overflow, 1);
    ob.data_out_ready = 1'b1;
    drive(1);
    chk("hold_next", ob.data_out, 64'h1033_1032_1031_1030);
    chk("hold_next_ts", ob.timestamp_out, 103);
    drive(0);
    chk("hold_drained", ob.data_out_valid, 0);
    chk("ovf_sticky", overflow, 1);

    // resync mid-beat with new K=2, then async reset while a beat is held.
    do_reset(3'd3);
    drive(1); drive(1);
    resync = 1'b1; cnt = 3'd2;
    drive(0);
    resync = 1'b0;
    drive(0);
    drive(1); drive(1);
    chk("rsy_data", ob.data_out, 64'h1031_1030_1021_1020);
    chk("rsy_ts", ob.timestamp_out, 102);
    chk("rsy_sync", ob.data_out_sync, 1);
    ob.data_out_ready = 1'b0;
    drive(1);
    chk("rsy_held", ob.data_out_valid, 1);
    do_reset(3'd4);

    // K configuration table, 20 en cycles each.
    tbl[0] = '{3'd0, 1'b1, 0};
    tbl[1] = '{3'd1, 1'b0, 5};
    tbl[2] = '{3'd2, 1'b0, 10};
    tbl[3] = '{3'd3, 1'b0, 15};
    tbl[4] = '{3'd4, 1'b0, 20};
    tbl[5] = '{3'd6, 1'b1, 0};
    tbl[6] = '{3'd5, 1'b1, 0};
    foreach (tbl[t]) begin
      do_reset(tbl[t].k);
      chk("cfg_err", config_err, tbl[t].err);
      nb = 0;
      for (int i = 0; i < 20; i++) begin
        drive(1);
        if (ob.data_out_valid) nb++;
      end
      drive(0);
      chk("cfg_beats", TW'(nb), TW'(tbl[t].beats));
    end

    // Leave ERR via resync with K=2.
    cnt = 3'd2; resync = 1'b1;
    drive(0);
    resync = 1'b0;
    drive(0);
    chk("err_cleared", config_err, 0);
    drive(1); drive(1);
    chk("err_recover_valid", ob.data_out_valid, 1);
    chk("err_recover_ts", ob.timestamp_out, 120);

`ifdef CPACK_TS_FLUSH_EN
    do_reset(3'd3);
    drive(1);
    flush = 1'b1;
    drive(0);
    flush = 1'b0;
    chk("flush_data", ob.data_out, 64'h0000_1002_1001_1000);
    chk("flush_sync", ob.data_out_sync, 1);
    chk("flush_ts", ob.timestamp_out, 100);
    drive(0);
    chk("flush_once", ob.data_out_valid, 0);
`endif

    // Random traffic against the model.
    for (int r = 0; r < 3; r++) begin
      do_reset(3'($urandom_range(1, 4)));
      for (int i = 0; i < 500; i++) begin
        ob.data_out_ready = ($urandom % 4) != 0;
        en     = $urandom % 3 != 0;
        resync = ($urandom % 40) == 0;
        if (resync) cnt = 3'($urandom_range(0, 5));
        din  = {$urandom, $urandom};
        tsin = {$urandom, $urandom};
        cyc();
      end
      resync = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/util_cpack_ts_stream.md
Name: util_cpack_ts_stream

Overview:
- Parametrised successor to the fixed 4-channel timestamp packer.
- Packs K enabled channels (1..NUM_OF_CHANNELS, any value, not only divisors) of CHANNEL_WIDTH samples into NUM_OF_CHANNELS-word output beats.
- Each beat carries the timestamp of the input cycle that supplied its word 0.
- Adds output valid/ready backpressure with a one-beat holding register and a sticky overflow flag. Sits between ADC channel selection and the DMA write interface.

Parameters:
NUM_OF_CHANNELS, 4, output beat width in words; input channel count (>=1)
CHANNEL_WIDTH, 16, bits per sample word
TIMESTAMP_WIDTH, 64, timestamp bus width

Ports:
clk  in  1  module clock
resetn  in  1  asynchronous active-low reset
enabled_chan_count  in  $clog2(N+1)  K, enabled channels; sampled only in IDLE
resync  in  1  synchronous pulse: discard partial beat, re-latch K
en  in  1  input sample cycle valid
data_in  in  N*W  channel c at [c*W +: W]; enabled channels occupy the lowest K slots
timestamp_in  in  TIMESTAMP_WIDTH  timestamp of current input cycle
data_out_ready  in  1  downstream accept
data_out_valid  out  1  beat available
data_out_sync  out  1  word 0 of beat is a channel-0 sample
data_out  out  N*W  packed beat, word 0 in LSBs
timestamp_out  out  TIMESTAMP_WIDTH  timestamp of the input cycle supplying word 0
overflow  out  1  sticky: a completed beat was dropped
config_err  out  1  latched K is 0 or >N

Behaviour:
- Reset (resetn low, async): state=IDLE, level=0, data_out_valid=0, data_out_sync=0, data_out=0, timestamp_out=0, overflow=0, config_err=0.
- States:
  - IDLE: latch K on the first clk edge after reset release, or the cycle after resync. K in 1..N -> RUN. Otherwise -> ERR with config_err=1.
  - RUN: packing.
  - ERR: ignore en, emit nothing. resync -> IDLE.
- Accumulator: 2N-word buffer plus level (0..N-1) and a pending-timestamp register.
  - On en in RUN: write K words at positions level..level+K-1.
  - If level==0, capture timestamp_in as pending timestamp and pending sync=1.
  - If level+K>=N:
    - Complete the beat with words 0..N-1, the pending timestamp and the pending sync.
    - Shift the remaining level+K-N words to position 0. New level = level+K-N.
    - If new level>0, pending timestamp = timestamp_in and pending sync=0.
  - Otherwise level += K.
  - Invariant: level+K < 2N.
- Latency: a beat completed at edge t appears on data_out_valid after edge t (one register stage).
- Output register:
  - data_out_valid holds until data_out_ready. data_out, data_out_sync and timestamp_out are stable while valid && !ready.
  - Completed beat with register empty or being accepted this cycle: load it.
  - Completed beat with register full and ready=0: drop it, set overflow=1, leave the register untouched. Packing continues.
  - overflow clears only on resetn.
- resync in RUN: level=0, partial data discarded, go to IDLE. The output register and a pending valid beat are kept. resync wins over a simultaneous en.
- Changing enabled_chan_count while in RUN has no effect until resync.
- en=0: no state change.

Optional Feature:
- Macro CPACK_TS_FLUSH_EN.
- Defined:
  - Adds input port flush (1 bit).
  - flush in RUN with level>0: emit the partial beat, words >=level zero-filled, with the pending timestamp and sync. Then level=0.
  - flush with level==0: no action.
  - flush coincident with en: append this cycle's words first, then flush.
  - Output register and overflow rules are identical to a normal beat.
- Not defined: no flush port; partial data is lost only on resync or reset.

Decomposition:
- Package cpack_ts_pkg: state enum (IDLE, RUN, ERR); localparams LEVEL_W=$clog2(2*N), CNT_W=$clog2(N+1).
- Sub-module cpack_ts_out_reg: valid/ready holding register with drop/overflow logic; data and timestamp widths as parameters.

Test Plan (N=4, W=16; sample on input cycle i, channel c = 0x1000+16i+c; timestamp_in = 100+i):
- K=4, en every cycle, ready=1 -> one beat per cycle, latency 1. Beat i = {c3..c0 of i}, sync=1, timestamp_out = 100+i.
- K=3, ready=1, cycles 0..3 -> three beats:
  - Beat 1: {0x1010,0x1002,0x1001,0x1000}, ts 100, sync=1.
  - Beat 2: {0x1021,0x1020,0x1012,0x1011}, ts 101, sync=0.
  - Beat 3: {0x1032,0x1031,0x1030,0x1022}, ts 102, sync=0.
  - Pattern then repeats.
- K=1 with en toggling 1,0 -> beat every 8 clk = {0x1030,0x1020,0x1010,0x1000}, ts 100, sync=1. Gaps cause no state change.
- K=4, ready=0 for 3 cycles -> first beat held stable, second and third dropped, overflow=1 (sticky). ready=1 -> held beat accepted, then cycle-3 beat follows.
- K=3, resync after cycle 1 with enabled_chan_count changed to 2 -> partial words discarded. Next beat = cycles 2+3 channels 0..1, ts 102, sync=1. Assert resetn low mid-beat -> all outputs 0 immediately, asynchronously.
- K=0, then K=5 -> config_err=1 and no data_out_valid for 20 cycles. resync with K=2 -> config_err=0, normal beats. With CPACK_TS_FLUSH_EN: K=3, one en, then flush -> {0,0x1002,0x1001,0x1000}, sync=1.
